inst_cache: RTL
===============

# inst_cache

Direct-mapped instruction cache between the instruction fetch unit (IFU) and the memory controller.
- Serves 32-bit instruction words to the IFU.
- On a miss, requests a whole 128-bit block from the memory controller over the fetch port (pc / enable / rollback / finish / block), fills the line, then answers the IFU.
- Drops an in-flight miss when the IFU signals a rollback.

## Interface
Parameters:
- `INDEX_BITS`, default 4: line index width; the cache has 2^INDEX_BITS lines.
- `BLOCK_BITS`, default 128: line size in bits. Must equal `ICACHE_INST_BLOCK_SIZE`.

Ports (`name  direction  width  meaning`):
- `clk  in  1`: single clock.
- `rst  in  1`: asynchronous, active-high reset.
- `rdy  in  1`: global ready. When low, all state holds.
- `pc_from_ifu  in  32`: fetch address. Bits [1:0] are ignored.
- `req_from_ifu  in  1`: one-cycle request pulse. The IFU issues no new request until `hit_to_ifu` or its own rollback.
- `rollback_from_ifu  in  1`: flush of the pending request.
- `hit_to_ifu  out  1`: one-cycle pulse; `inst_to_ifu` is valid in that cycle.
- `inst_to_ifu  out  32`: instruction word.
- `pc_to_mc  out  32`: block-aligned fetch address, {pc[31:4], 4'b0}.
- `enable_to_mc  out  1`: one-cycle fetch request pulse to the memory controller.
- `rollback_to_mc  out  1`: one-cycle cancel pulse to the memory controller.
- `finish_from_mc  in  1`: one-cycle pulse; the block is valid in that cycle.
- `block_from_mc  in  128`: little-endian block. Byte i is at bits [8i+7:8i].

## Operation
Address split:
- offset = pc[3:2]
- index = pc[4+INDEX_BITS-1:4]
- tag = pc[31:4+INDEX_BITS]

Word selection: word w of a line or block = bits [32w+31:32w].

States: IDLE and WAIT.

IDLE, with `req_from_ifu` high and `rollback_from_ifu` low:
- Hit (valid[index] && tag match): register `hit_to_ifu`=1 and `inst_to_ifu` = selected word. Stay in IDLE.
- Miss: latch pc, drive `pc_to_mc` with the aligned pc, pulse `enable_to_mc` for one cycle, go to WAIT.

WAIT:
- On `finish_from_mc`:
  - Write data, tag and valid into the line at the latched index.
  - Pulse `hit_to_ifu` with the word selected from `block_from_mc` (not from the array).
  - Go to IDLE.
- On `rollback_from_ifu`: pulse `rollback_to_mc`, go to IDLE, no hit.

Boundary rules:
- Rollback in the same cycle as a request: the rollback wins and the request is ignored.
- Rollback in the same cycle as `finish_from_mc`: the line is still written, but no hit pulse is sent and no `rollback_to_mc` is sent.
- Rollback in IDLE: no `rollback_to_mc`. A hit registered in the previous cycle is not retracted.
- A request arriving during WAIT is a protocol violation and is ignored.
- A refill overwrites whatever line is at that index, valid or not.

Reset:
- All valid bits are cleared.
- Outputs go to: hit 0, inst 0, pc_to_mc 0, enable 0, rollback 0.
- State goes to IDLE.
- Reset in the middle of WAIT abandons the miss silently; the memory controller is reset by the same `rst`.

## Timing
- All outputs are registered. Pulses last exactly one cycle (the cycle after the triggering edge).
- Hit latency: request sampled at edge N → `hit_to_ifu` high during cycle N+1.
- Miss: request sampled at edge N → `enable_to_mc` high during N+1. `finish_from_mc` sampled at edge M → `hit_to_ifu` high during M+1.
- A line written at edge M is visible to a request sampled at edge M+1.
- While `rdy` is low:
  - No state changes and no new pulses.
  - Outputs hold their current values.
  - Pulse outputs are driven low.

## Configuration
- `ICACHE_STATS_EN` defined: adds output ports `hit_count` (32) and `miss_count` (32).
  - Both are saturating counters, cleared by reset.
  - Each counts accepted (non-rolled-back) requests that hit or miss respectively.
- `ICACHE_STATS_EN` undefined: the ports and counters do not exist. Behaviour is otherwise identical.

## Structure
- Shared `defines.v` holds `ADDR_TYPE`, `ICACHE_INST_BLOCK_SIZE` (128), `TRUE`/`FALSE`, `NULL`, and the new `ICACHE_INDEX_BITS`.
- One sub-module, `icache_line_array`: valid/tag/data storage with asynchronous read, synchronous write, and asynchronous clear on reset.

## Test plan
- Cold miss: reset, then request pc=0x0000_0008 with finish returning block 0x33333333_22222222_11111111_00000000 → `enable_to_mc` pulse with `pc_to_mc`=0x0, then hit with inst=0x22222222.
- Warm hit: after the cold-miss scenario, request pc=0x0000_000C → hit in the next cycle with inst=0x33333333, and no `enable_to_mc`.
- Conflict eviction: request pc=0x0000_0100 (same index, tag 1) and fill it, then request 0x0000_0000 → a miss again, with a new `enable_to_mc`.
- Rollback during WAIT: miss on 0x40, rollback two cycles later → `rollback_to_mc` pulse, no hit, state back to IDLE. A repeat request for 0x40 misses.
- Rollback coincident with finish: line filled, no hit. The next request to the same block hits in 1 cycle.
- `rdy` low for 3 cycles during WAIT with finish held off: no outputs change. Finish after `rdy` rises → hit in the next cycle.

Source files
------------

// File: rtl/inst_cache_pkg.sv
// inst_cache_pkg: shared address/block constants, FSM state type and word-select helper for inst_cache
package inst_cache_pkg;
  localparam int ADDR_WIDTH = 32;
  localparam int ICACHE_INST_BLOCK_SIZE = 128;
  localparam int ICACHE_INDEX_BITS = 4;
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef enum logic {IDLE, WAIT} state_t;
  function automatic logic [31:0] word_sel(input logic [ICACHE_INST_BLOCK_SIZE-1:0] b, input logic [1:0] w);
    return b[32*w +: 32];
  endfunction
endpackage

// File: rtl/inst_cache_if.sv
// inst_cache_if: IFU fetch and memory-controller refill signals; slave = cache side, master = IFU/MC side
interface inst_cache_if #(parameter int BLOCK_BITS = 128);
  logic [31:0] pc_from_ifu;
  logic req_from_ifu;
  logic rollback_from_ifu;
  logic hit_to_ifu;
  logic [31:0] inst_to_ifu;
  logic [31:0] pc_to_mc;
  logic enable_to_mc;
  logic rollback_to_mc;
  logic finish_from_mc;
  logic [BLOCK_BITS-1:0] block_from_mc;
  modport slave(
    input pc_from_ifu, req_from_ifu, rollback_from_ifu, finish_from_mc, block_from_mc,
    output hit_to_ifu, inst_to_ifu, pc_to_mc, enable_to_mc, rollback_to_mc
  );
  modport master(
    output pc_from_ifu, req_from_ifu, rollback_from_ifu, finish_from_mc, block_from_mc,
    input hit_to_ifu, inst_to_ifu, pc_to_mc, enable_to_mc, rollback_to_mc
  );
endinterface

// File: rtl/icache_line_array.sv
// icache_line_array: valid/tag/data storage; async read, sync write, valid bits cleared async by rst
module icache_line_array #(
  parameter int INDEX_BITS = 4,
  parameter int TAG_BITS = 24,
  parameter int BLOCK_BITS = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [INDEX_BITS-1:0] windex,
  input  logic [TAG_BITS-1:0]   wtag,
  input  logic [BLOCK_BITS-1:0] wdata,
  input  logic [INDEX_BITS-1:0] rindex,
  output logic                  rvalid,
  output logic [TAG_BITS-1:0]   rtag,
  output logic [BLOCK_BITS-1:0] rdata
);
  localparam int LINES = 1 << INDEX_BITS;
  logic [LINES-1:0] valid;
  logic [TAG_BITS-1:0] tags [LINES];
  logic [BLOCK_BITS-1:0] data [LINES];
  always_ff @(posedge clk or posedge rst)
    if (rst) valid <= '0;
    else if (we) valid[windex] <= 1'b1;
  always_ff @(posedge clk)
    if (we) begin
      tags[windex] <= wtag;
      data[windex] <= wdata;
    end
  assign rvalid = valid[rindex];
  assign rtag = tags[rindex];
  assign rdata = data[rindex];
endmodule

// File: rtl/inst_cache.sv
// inst_cache: direct-mapped instruction cache between IFU and memory controller
// ports: clk, rst (async, active-high), rdy (global stall), bus (inst_cache_if.slave);
// with ICACHE_STATS_EN defined, adds saturating hit_count/miss_count outputs
module inst_cache
  import inst_cache_pkg::*;
#(
  parameter int INDEX_BITS = ICACHE_INDEX_BITS,
  parameter int BLOCK_BITS = ICACHE_INST_BLOCK_SIZE
) (
  input  logic clk,
  input  logic rst,
  input  logic rdy,
  inst_cache_if.slave bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);
  localparam int TAG_BITS = 32 - 4 - INDEX_BITS;
  state_t state_q, state_d;
  logic [1:0] off_q, off_d;
  logic hit_d, en_d, rb_d, we, line_hit, rvalid, accept;
  logic [31:0] inst_d;
  addr_t pc_mc_d;
  logic [TAG_BITS-1:0] rtag;
  logic [BLOCK_BITS-1:0] rdata;
  logic unused;
  assign unused = ^bus.pc_from_ifu[1:0];
  icache_line_array #(.INDEX_BITS(INDEX_BITS), .TAG_BITS(TAG_BITS), .BLOCK_BITS(BLOCK_BITS)) u_lines (
    .clk(clk),
    .rst(rst),
    .we(we && rdy),
    .windex(bus.pc_to_mc[4 +: INDEX_BITS]),
    .wtag(bus.pc_to_mc[4+INDEX_BITS +: TAG_BITS]),
    .wdata(bus.block_from_mc),
    .rindex(bus.pc_from_ifu[4 +: INDEX_BITS]),
    .rvalid(rvalid),
    .rtag(rtag),
    .rdata(rdata)
  );
  assign line_hit = rvalid && rtag == bus.pc_from_ifu[4+INDEX_BITS +: TAG_BITS];
  assign accept = state_q == IDLE && bus.req_from_ifu && !bus.rollback_from_ifu;
  always_comb begin
    state_d = state_q;
    off_d = off_q;
    hit_d = 1'b0;
    inst_d = bus.inst_to_ifu;
    pc_mc_d = bus.pc_to_mc;
    en_d = 1'b0;
    rb_d = 1'b0;
    we = 1'b0;
    if (accept && line_hit) begin
      hit_d = 1'b1;
      inst_d = word_sel(rdata, bus.pc_from_ifu[3:2]);
    end else if (accept) begin
      off_d = bus.pc_from_ifu[3:2];
      pc_mc_d = {bus.pc_from_ifu[31:4], 4'b0};
      en_d = 1'b1;
      state_d = WAIT;
    end
    if (state_q == WAIT && bus.finish_from_mc) begin
      // a coincident rollback still fills the line but suppresses the answer
      we = 1'b1;
      state_d = IDLE;
      hit_d = !bus.rollback_from_ifu;
      inst_d = bus.rollback_from_ifu ? bus.inst_to_ifu : word_sel(bus.block_from_mc, off_q);
    end else if (state_q == WAIT && bus.rollback_from_ifu) begin
      rb_d = 1'b1;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      off_q <= '0;
      bus.hit_to_ifu <= 1'b0;
      bus.inst_to_ifu <= '0;
      bus.pc_to_mc <= '0;
      bus.enable_to_mc <= 1'b0;
      bus.rollback_to_mc <= 1'b0;
    end else if (rdy) begin
      state_q <= state_d;
      off_q <= off_d;
      bus.hit_to_ifu <= hit_d;
      bus.inst_to_ifu <= inst_d;
      bus.pc_to_mc <= pc_mc_d;
      bus.enable_to_mc <= en_d;
      bus.rollback_to_mc <= rb_d;
    end else begin
      bus.hit_to_ifu <= 1'b0;
      bus.enable_to_mc <= 1'b0;
      bus.rollback_to_mc <= 1'b0;
    end
`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hit_count <= '0;
      miss_count <= '0;
    end else if (rdy && accept) begin
      if (line_hit && ~&hit_count) hit_count <= hit_count + 32'd1;
      if (!line_hit && ~&miss_count) miss_count <= miss_count + 32'd1;
    end
`endif
endmodule
